// File: rtl/decode_unit.sv
// -----------------------------------------------------------------------------
// decode_unit
//   Producer side of the ALU operand interface of the multi-cycle RV32I core.
//   One instruction is in flight at a time and walks through five stages:
//     0 IDLE   - ready_o high, an offered instruction is latched into the IR
//     1 DECODE - opcode classified; unsupported encodings pulse illegal_o and
//                return to IDLE
//     2 READ   - operands a/b/pass registered, all three load strobes high
//     3 EXEC   - the ALU computes y
//     4 WB     - wb_data_i written to rd for R/I/U/J types (never to x0)
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   instr_valid_i/instr_i/pc_i   offered instruction and its PC
//   ready_o                      high only in IDLE
//   wb_data_i                    ALU result, sampled in WB
//   stage_o, ir_o, itype_o       current stage, IR, type code
//   readd_{a,b,pass}_o           operands (held until the next READ)
//   readin_{a,b,pass}_o          one-cycle load strobes
//   illegal_o                    one-cycle pulse during DECODE
//
// Configuration
//   DECODE_MEXT_EN : when defined, R-type with funct7=0000001 (RV32M) is
//                    accepted as RTYPE; otherwise it is reported as illegal.
// -----------------------------------------------------------------------------
`ifndef RTYPE
`define RTYPE 5'd1
`define ITYPE 5'd2
`define STYPE 5'd3
`define BTYPE 5'd4
`define UTYPE 5'd5
`define JTYPE 5'd6
`endif

module decode_unit #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            instr_valid_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [2:0]      stage_o,
    output logic [31:0]     ir_o,
    output logic [4:0]      itype_o,
    output logic [XLEN-1:0] readd_a_o,
    output logic [XLEN-1:0] readd_b_o,
    output logic [XLEN-1:0] readd_pass_o,
    output logic            readin_a_o,
    output logic            readin_b_o,
    output logic            readin_pass_o,
    output logic            illegal_o
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DEC  = 3'd1;
    localparam logic [2:0] ST_READ = 3'd2;
    localparam logic [2:0] ST_EXEC = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;

    // Returns the type code of an instruction word, or 0 when unsupported.
    function automatic logic [4:0] classify(input logic [31:0] ins);
        logic [4:0] t;
        t = 5'd0;
        case (ins[6:0])
            7'b0110011: begin
                if ((ins[31:25] == 7'b0000000) || (ins[31:25] == 7'b0100000)) begin
                    t = `RTYPE;
                end
`ifdef DECODE_MEXT_EN
                else if (ins[31:25] == 7'b0000001) begin
                    t = `RTYPE;
                end
`endif
                else begin
                    t = 5'd0;
                end
            end
            7'b0010011, 7'b0000011, 7'b1100111: t = `ITYPE;
            7'b0100011:                         t = `STYPE;
            7'b1100011:                         t = `BTYPE;
            7'b0110111, 7'b0010111:             t = `UTYPE;
            7'b1101111:                         t = `JTYPE;
            default:                            t = 5'd0;
        endcase
        return t;
    endfunction

    logic [2:0]      stage_r, stage_next_s;
    logic [31:0]     ir_r;
    logic [XLEN-1:0] pc_r;
    logic [4:0]      itype_r;
    logic [XLEN-1:0] opa_r, opb_r, opp_r;
    logic            strobe_r;
    logic            illegal_r;
    logic [XLEN-1:0] regs_r [NREGS];

    logic [4:0]      dec_type_s;
    logic [XLEN-1:0] rs1_val_s, rs2_val_s;
    logic [XLEN-1:0] opa_s, opb_s, opp_s;
    logic            writes_s;
    logic            accept_s;

    assign accept_s   = (stage_r == ST_IDLE) && instr_valid_i;
    assign dec_type_s = classify(ir_r);
    assign rs1_val_s  = (ir_r[19:15] == 5'd0) ? {XLEN{1'b0}} : regs_r[ir_r[19:15]];
    assign rs2_val_s  = (ir_r[24:20] == 5'd0) ? {XLEN{1'b0}} : regs_r[ir_r[24:20]];

    // Stage register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_r <= ST_IDLE;
        end else begin
            stage_r <= stage_next_s;
        end
    end

    // Next-stage logic; an illegal instruction leaves DECODE straight to IDLE.
    always_comb begin
        stage_next_s = ST_IDLE;
        case (stage_r)
            ST_IDLE: begin
                if (instr_valid_i) stage_next_s = ST_DEC;
                else               stage_next_s = ST_IDLE;
            end
            ST_DEC: begin
                if (illegal_r) stage_next_s = ST_IDLE;
                else           stage_next_s = ST_READ;
            end
            ST_READ: stage_next_s = ST_EXEC;
            ST_EXEC: stage_next_s = ST_WB;
            ST_WB:   stage_next_s = ST_IDLE;
            default: stage_next_s = ST_IDLE;
        endcase
    end

    // Operand selection from the IR, consumed at the end of DECODE.
    always_comb begin
        opa_s = {XLEN{1'b0}};
        opb_s = {XLEN{1'b0}};
        opp_s = {XLEN{1'b0}};
        case (dec_type_s)
            `RTYPE: begin
                opa_s = rs1_val_s;
                opb_s = rs2_val_s;
            end
            `ITYPE: begin
                opa_s = rs1_val_s;
                opb_s = {{20{ir_r[31]}}, ir_r[31:20]};
                opp_s = pc_r;
            end
            `STYPE: begin
                opa_s = rs1_val_s;
                opb_s = {{20{ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
                opp_s = rs2_val_s;
            end
            `BTYPE: begin
                opa_s = rs1_val_s;
                opb_s = rs2_val_s;
                opp_s = {{19{ir_r[31]}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
            end
            `UTYPE: begin
                // LUI adds to zero, AUIPC adds to the PC.
                if (ir_r[6:0] == 7'b0110111) opa_s = {XLEN{1'b0}};
                else                         opa_s = pc_r;
                opb_s = {ir_r[31:12], 12'h000};
            end
            `JTYPE: begin
                opa_s = pc_r;
                opb_s = 32'd4;
                opp_s = {{11{ir_r[31]}}, ir_r[31], ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};
            end
            default: begin
                opa_s = {XLEN{1'b0}};
                opb_s = {XLEN{1'b0}};
                opp_s = {XLEN{1'b0}};
            end
        endcase
    end

    // Writeback enable from the registered type code.
    always_comb begin
        writes_s = 1'b0;
        case (itype_r)
            `RTYPE, `ITYPE, `UTYPE, `JTYPE: writes_s = 1'b1;
            default:                        writes_s = 1'b0;
        endcase
    end

    // IR/PC capture, decode results, operand registers and strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_r      <= 32'h0000_0000;
            pc_r      <= {XLEN{1'b0}};
            itype_r   <= 5'd0;
            opa_r     <= {XLEN{1'b0}};
            opb_r     <= {XLEN{1'b0}};
            opp_r     <= {XLEN{1'b0}};
            strobe_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            if (accept_s) begin
                ir_r <= instr_i;
                pc_r <= pc_i;
            end
            // Classified from instr_i at capture so the pulse lands in DECODE.
            illegal_r <= accept_s && (classify(instr_i) == 5'd0);
            strobe_r  <= (stage_r == ST_DEC) && !illegal_r;
            if (stage_r == ST_DEC) begin
                itype_r <= dec_type_s;
            end
            if ((stage_r == ST_DEC) && !illegal_r) begin
                opa_r <= opa_s;
                opb_r <= opb_s;
                opp_r <= opp_s;
            end
        end
    end

    // Register file; x0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            if ((stage_r == ST_WB) && writes_s && (ir_r[11:7] != 5'd0)) begin
                regs_r[ir_r[11:7]] <= wb_data_i;
            end
        end
    end

    assign ready_o       = (stage_r == ST_IDLE);
    assign stage_o       = stage_r;
    assign ir_o          = ir_r;
    assign itype_o       = itype_r;
    assign readd_a_o     = opa_r;
    assign readd_b_o     = opb_r;
    assign readd_pass_o  = opp_r;
    assign readin_a_o    = strobe_r;
    assign readin_b_o    = strobe_r;
    assign readin_pass_o = strobe_r;
    assign illegal_o     = illegal_r;

endmodule

// File: tb/tb_decode_unit.sv
// -----------------------------------------------------------------------------
// tb_decode_unit
//   Directed self-checking bench for decode_unit. Each test task issues one or
//   more instructions and compares the observed stage sequence, strobes,
//   operands and writeback effects against hand-computed values.
// -----------------------------------------------------------------------------
`ifndef RTYPE
`define RTYPE 5'd1
`define ITYPE 5'd2
`define STYPE 5'd3
`define BTYPE 5'd4
`define UTYPE 5'd5
`define JTYPE 5'd6
`endif

module tb_decode_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_valid_i;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        ready_o;
    logic [31:0] wb_data_i;
    logic [2:0]  stage_o;
    logic [31:0] ir_o;
    logic [4:0]  itype_o;
    logic [31:0] readd_a_o, readd_b_o, readd_pass_o;
    logic        readin_a_o, readin_b_o, readin_pass_o;
    logic        illegal_o;

    int total = 0;
    int bad   = 0;

    // observations captured by issue()
    logic [31:0] pc_next = 32'h0000_0100;
    logic [31:0] obs_pc;
    logic [2:0]  obs_st [5];
    logic [31:0] obs_a, obs_b, obs_p;
    logic [4:0]  obs_it;
    logic        obs_all;
    logic        obs_ill1;
    int          ill_cnt, str_cnt;

    decode_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .instr_valid_i (instr_valid_i),
        .instr_i       (instr_i),
        .pc_i          (pc_i),
        .ready_o       (ready_o),
        .wb_data_i     (wb_data_i),
        .stage_o       (stage_o),
        .ir_o          (ir_o),
        .itype_o       (itype_o),
        .readd_a_o     (readd_a_o),
        .readd_b_o     (readd_b_o),
        .readd_pass_o  (readd_pass_o),
        .readin_a_o    (readin_a_o),
        .readin_b_o    (readin_b_o),
        .readin_pass_o (readin_pass_o),
        .illegal_o     (illegal_o)
    );

    always #5 clk = ~clk;

    // Offers one instruction at a negedge in stage 0 and records five cycles.
    task automatic issue(input logic [31:0] ins, input logic [31:0] wb);
        instr_valid_i = 1'b1;
        instr_i       = ins;
        pc_i          = pc_next;
        wb_data_i     = wb;
        obs_pc        = pc_next;
        pc_next       = pc_next + 32'd4;
        obs_a = 32'hxxxx_xxxx; obs_b = 32'hxxxx_xxxx; obs_p = 32'hxxxx_xxxx;
        obs_it = 5'bxxxxx; obs_all = 1'bx;
        ill_cnt = 0; str_cnt = 0;
        @(negedge clk);
        instr_valid_i = 1'b0;
        obs_ill1 = illegal_o;
        for (int k = 0; k < 5; k++) begin
            obs_st[k] = stage_o;
            if (illegal_o) ill_cnt++;
            if (readin_a_o || readin_b_o || readin_pass_o) str_cnt++;
            if (stage_o == 3'd2) begin
                obs_a   = readd_a_o;
                obs_b   = readd_b_o;
                obs_p   = readd_pass_o;
                obs_it  = itype_o;
                obs_all = readin_a_o & readin_b_o & readin_pass_o;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; instr_valid_i = 1'b0; instr_i = 32'd0; pc_i = 32'd0; wb_data_i = 32'd0;
        @(negedge clk); @(negedge clk);
        total++; if (stage_o !== 3'd0) begin bad++; $display("FAIL rst_stage got=%0d exp=0", stage_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ready_o); end
        total++; if ({ir_o, itype_o, readd_a_o, readd_b_o, readd_pass_o} !== 133'd0) begin
            bad++; $display("FAIL rst_regs ir=%h it=%0d a=%h b=%h p=%h exp=0", ir_o, itype_o, readd_a_o, readd_b_o, readd_pass_o); end
        total++; if ({readin_a_o, readin_b_o, readin_pass_o, illegal_o} !== 4'b0000) begin
            bad++; $display("FAIL rst_strobes got=%b%b%b%b exp=0000", readin_a_o, readin_b_o, readin_pass_o, illegal_o); end
        reset_n = 1'b1;
        @(negedge clk);
        issue(32'h0050_0093, 32'd5);        // ADDI x1,x0,5
        // ADDI x5,x0,9 aborted by reset during EXEC
        instr_valid_i = 1'b1; instr_i = 32'h0090_0293; pc_i = pc_next; wb_data_i = 32'd9;
        @(negedge clk); instr_valid_i = 1'b0;
        @(negedge clk); @(negedge clk);
        total++; if (stage_o !== 3'd3) begin bad++; $display("FAIL mid_stage got=%0d exp=3", stage_o); end
        #2 reset_n = 1'b0;
        #1;
        total++; if ({stage_o, readin_a_o, readin_b_o, readin_pass_o} !== 6'd0 || readd_a_o !== 32'd0) begin
            bad++; $display("FAIL mid_rst stage=%0d str=%b%b%b a=%h exp=0", stage_o, readin_a_o, readin_b_o, readin_pass_o, readd_a_o); end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        total++; if (ready_o !== 1'b1 || stage_o !== 3'd0) begin bad++; $display("FAIL post_rst ready=%b stage=%0d exp=1/0", ready_o, stage_o); end
        issue(32'h0012_8133, 32'd0);        // ADD x2,x5,x1: both cleared by reset
        total++; if (obs_a !== 32'd0 || obs_b !== 32'd0) begin bad++; $display("FAIL post_rst_read a=%h b=%h exp=0/0", obs_a, obs_b); end
    endtask

    task automatic test_addi_add();
        issue(32'h0050_0093, 32'd5);        // ADDI x1,x0,5
        total++; if (obs_it !== `ITYPE) begin bad++; $display("FAIL addi_type got=%0d exp=%0d", obs_it, `ITYPE); end
        total++; if (obs_a !== 32'd0 || obs_b !== 32'd5 || obs_p !== obs_pc) begin
            bad++; $display("FAIL addi_ops a=%h b=%h p=%h exp=0/5/%h", obs_a, obs_b, obs_p, obs_pc); end
        total++; if ({obs_st[0], obs_st[1], obs_st[2], obs_st[3], obs_st[4]} !== {3'd1, 3'd2, 3'd3, 3'd4, 3'd0}) begin
            bad++; $display("FAIL addi_seq got=%0d%0d%0d%0d%0d exp=12340", obs_st[0], obs_st[1], obs_st[2], obs_st[3], obs_st[4]); end
        issue(32'h0010_8133, 32'd10);       // ADD x2,x1,x1 (x2=10)
        total++; if (obs_a !== 32'd5 || obs_b !== 32'd5 || obs_p !== 32'd0) begin
            bad++; $display("FAIL add_ops a=%h b=%h p=%h exp=5/5/0", obs_a, obs_b, obs_p); end
        total++; if (obs_all !== 1'b1 || str_cnt != 1) begin bad++; $display("FAIL add_strobe all=%b cycles=%0d exp=1/1", obs_all, str_cnt); end
        total++; if (obs_it !== `RTYPE) begin bad++; $display("FAIL add_type got=%0d exp=%0d", obs_it, `RTYPE); end
        total++; if (readd_a_o !== 32'd5 || itype_o !== `RTYPE) begin bad++; $display("FAIL add_hold a=%h it=%0d exp=5/%0d", readd_a_o, itype_o, `RTYPE); end
    endtask

    task automatic test_lui();
        issue(32'h1234_51B7, 32'h1234_5000);  // LUI x3,0x12345
        total++; if (obs_a !== 32'd0 || obs_b !== 32'h1234_5000 || obs_p !== 32'd0) begin
            bad++; $display("FAIL lui_ops a=%h b=%h p=%h exp=0/12345000/0", obs_a, obs_b, obs_p); end
        total++; if (obs_it !== `UTYPE) begin bad++; $display("FAIL lui_type got=%0d exp=%0d", obs_it, `UTYPE); end
        issue(32'h0001_8233, 32'd0);          // ADD x4,x3,x0
        total++; if (obs_a !== 32'h1234_5000 || obs_b !== 32'd0) begin bad++; $display("FAIL lui_wb a=%h b=%h exp=12345000/0", obs_a, obs_b); end
    endtask

    task automatic test_store();
        issue(32'h0020_A423, 32'hDEAD_BEEF);  // SW x2,8(x1)
        total++; if (obs_a !== 32'd5 || obs_b !== 32'd8 || obs_p !== 32'd10) begin
            bad++; $display("FAIL sw_ops a=%h b=%h p=%h exp=5/8/a", obs_a, obs_b, obs_p); end
        total++; if (obs_it !== `STYPE) begin bad++; $display("FAIL sw_type got=%0d exp=%0d", obs_it, `STYPE); end
        issue(32'h0004_03B3, 32'd0);          // ADD x7,x8,x0: x8 must be untouched
        total++; if (obs_a !== 32'd0) begin bad++; $display("FAIL sw_nowb x8=%h exp=0", obs_a); end
        issue(32'h0020_8333, 32'd0);          // ADD x6,x1,x2
        total++; if (obs_a !== 32'd5 || obs_b !== 32'd10) begin bad++; $display("FAIL sw_regs a=%h b=%h exp=5/a", obs_a, obs_b); end
    endtask

    task automatic test_branch();
        issue(32'hFE20_8CE3, 32'h0000_0055);  // BEQ x1,x2,-8
        total++; if (obs_a !== 32'd5 || obs_b !== 32'd10 || obs_p !== 32'hFFFF_FFF8) begin
            bad++; $display("FAIL beq_ops a=%h b=%h p=%h exp=5/a/fffffff8", obs_a, obs_b, obs_p); end
        total++; if (obs_it !== `BTYPE) begin bad++; $display("FAIL beq_type got=%0d exp=%0d", obs_it, `BTYPE); end
        issue(32'h000C_8233, 32'd0);          // ADD x4,x25,x0: rd field of BEQ is x25
        total++; if (obs_a !== 32'd0) begin bad++; $display("FAIL beq_nowb x25=%h exp=0", obs_a); end
    endtask

    task automatic test_x0();
        issue(32'h0070_0013, 32'd7);          // ADDI x0,x0,7
        issue(32'h0000_04B3, 32'd0);          // ADD x9,x0,x0
        total++; if (obs_a !== 32'd0 || obs_b !== 32'd0) begin bad++; $display("FAIL x0_read a=%h b=%h exp=0/0", obs_a, obs_b); end
    endtask

    task automatic test_illegal();
        issue(32'h0000_007F, 32'd1);
        total++; if (obs_ill1 !== 1'b1 || obs_st[0] !== 3'd1) begin
            bad++; $display("FAIL ill_pulse ill=%b stage=%0d exp=1/1", obs_ill1, obs_st[0]); end
        total++; if (ill_cnt != 1) begin bad++; $display("FAIL ill_len cycles=%0d exp=1", ill_cnt); end
        total++; if (obs_st[1] !== 3'd0) begin bad++; $display("FAIL ill_next stage=%0d exp=0", obs_st[1]); end
        total++; if (str_cnt != 0) begin bad++; $display("FAIL ill_strobe cycles=%0d exp=0", str_cnt); end
    endtask

    task automatic test_mext();
        issue(32'h0220_8033, 32'd50);         // MUL x0,x1,x2
`ifdef DECODE_MEXT_EN
        total++; if (obs_ill1 !== 1'b0 || obs_it !== `RTYPE || obs_a !== 32'd5 || obs_b !== 32'd10) begin
            bad++; $display("FAIL mul_en ill=%b it=%0d a=%h b=%h exp=0/%0d/5/a", obs_ill1, obs_it, obs_a, obs_b, `RTYPE); end
`else
        total++; if (obs_ill1 !== 1'b1 || ill_cnt != 1 || str_cnt != 0 || obs_st[1] !== 3'd0) begin
            bad++; $display("FAIL mul_dis ill=%b n=%0d str=%0d st=%0d exp=1/1/0/0", obs_ill1, ill_cnt, str_cnt, obs_st[1]); end
`endif
    endtask

    task automatic test_upper_jump();
        issue(32'h0000_1297, 32'd0);          // AUIPC x5,1
        total++; if (obs_a !== obs_pc || obs_b !== 32'h0000_1000 || obs_p !== 32'd0 || obs_it !== `UTYPE) begin
            bad++; $display("FAIL auipc a=%h b=%h p=%h it=%0d exp=%h/1000/0/%0d", obs_a, obs_b, obs_p, obs_it, obs_pc, `UTYPE); end
        issue(32'h0100_056F, 32'h0000_0ABC);  // JAL x10,+16
        total++; if (obs_a !== obs_pc || obs_b !== 32'd4 || obs_p !== 32'd16 || obs_it !== `JTYPE) begin
            bad++; $display("FAIL jal a=%h b=%h p=%h it=%0d exp=%h/4/10/%0d", obs_a, obs_b, obs_p, obs_it, obs_pc, `JTYPE); end
        issue(32'h0005_0233, 32'd0);          // ADD x4,x10,x0
        total++; if (obs_a !== 32'h0000_0ABC) begin bad++; $display("FAIL jal_wb x10=%h exp=abc", obs_a); end
    endtask

    task automatic test_back_to_back();
        // valid held high through a whole instruction is only sampled in stage 0
        instr_valid_i = 1'b1; instr_i = 32'h0010_8133; pc_i = pc_next; wb_data_i = 32'd0;
        @(negedge clk);
        instr_i = 32'h0000_007F;
        @(negedge clk);
        total++; if (stage_o !== 3'd2 || illegal_o !== 1'b0 || ir_o !== 32'h0010_8133) begin
            bad++; $display("FAIL b2b_ignore st=%0d ill=%b ir=%h exp=2/0/00108133", stage_o, illegal_o, ir_o); end
        @(negedge clk); @(negedge clk); @(negedge clk);
        @(negedge clk);
        total++; if (stage_o !== 3'd1 || illegal_o !== 1'b1) begin
            bad++; $display("FAIL b2b_next st=%0d ill=%b exp=1/1", stage_o, illegal_o); end
        instr_valid_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_addi_add();
        test_lui();
        test_store();
        test_branch();
        test_x0();
        test_illegal();
        test_mext();
        test_upper_jump();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
